spin_readout: RTL
=================

SPIN_READOUT -- requirements
Module: spin_readout

Interface
REQ-001 Parameter NUM_SPINS, default 8: number of oscillator phase inputs sampled.
REQ-002 Parameter CNT_W, default 16: width of per-spin mismatch counters and of the sample-window length.
REQ-003 Port clk, input, 1: single clock for all sequential logic.
REQ-004 Port axi_rstn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port start, input, 1: one-cycle request to begin an anneal-and-read run.
REQ-006 Port rst_cycles, input, 16: number of cycles to hold the oscillator array in reset.
REQ-007 Port run_cycles, input, 32: number of cycles the array settles before sampling.
REQ-008 Port sample_cycles, input, CNT_W: sample-window length in cycles.
REQ-009 Port ref_in, input, 1: asynchronous reference-oscillator phase.
REQ-010 Port phase_in, input, NUM_SPINS: asynchronous spin-oscillator phases from the coupled array.
REQ-011 Port rd_idx, input, $clog2(NUM_SPINS): spin selector for rdata.
REQ-012 Port ising_rstn, output, 1: active-low reset driven to the oscillator array.
REQ-013 Port busy, output, 1: run in progress.
REQ-014 Port done, output, 1: sticky; results valid.
REQ-015 Port spins, output, NUM_SPINS: decided spin values.
REQ-016 Port rdata, output, 32: zero-extended mismatch count of spin rd_idx.

Function
REQ-017 ref_in and each phase_in bit SHALL pass through a two-flop synchronizer before any use; only synchronized values are counted.
REQ-018 The FSM SHALL have states IDLE, HOLD, RUN, SAMPLE, DONE; IDLE is the reset state.
REQ-019 In IDLE or DONE, start=1 SHALL move to HOLD on the next edge, clear done, spins and all counters, and load the cycle counter.
REQ-020 start SHALL be ignored in HOLD, RUN and SAMPLE.
REQ-021 HOLD SHALL last max(rst_cycles,1) cycles with ising_rstn=0, then go to RUN.
REQ-022 RUN SHALL last max(run_cycles,1) cycles with ising_rstn=1, then go to SAMPLE.
REQ-023 SAMPLE SHALL last max(sample_cycles,1) cycles; each cycle, counter[i] increments when sync phase[i] != sync ref.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 On SAMPLE exit, spins[i] SHALL be 1 iff 2*counter[i] > effective window, computed at CNT_W+1 bits; ties give 0.
REQ-026 DONE SHALL hold done=1, spins and counters stable until the next start.
REQ-027 busy SHALL be 1 exactly in HOLD, RUN and SAMPLE.
REQ-028 ising_rstn SHALL be 0 in IDLE and HOLD, and 1 in RUN, SAMPLE and DONE, so the array keeps oscillating after reading.
REQ-029 rst_cycles, run_cycles and sample_cycles SHALL be captured at start acceptance; later changes have no effect on the current run.
REQ-030 rdata SHALL be a registered readback of counter[rd_idx], one cycle after rd_idx changes; an out-of-range rd_idx returns 0.

Reset
REQ-031 axi_rstn low SHALL asynchronously force state IDLE, ising_rstn=0, busy=0, done=0, spins=0, counters=0, rdata=0 and synchronizers=0.
REQ-032 Reset asserted mid-run SHALL abort the run with no partial results kept; the first start after release begins a fresh run.

Structure
REQ-033 FSM state encoding and the synchronizer depth constant (2) SHALL live in the shared defines header.
REQ-034 The synchronizer SHALL be a sub-module sync_2ff, instantiated per bit; counters and FSM are inline.

Verification
REQ-035 rst=3, run=10, sample=8, ref and phase[0] in phase, phase[1] inverted; start -> ising_rstn low 3 cycles, done after 3+10+8 cycles plus sync latency, spins[1:0]=2'b10, rdata(idx1)=8.
REQ-036 sample=8, phase[2] mismatched for exactly 4 window cycles -> counter=4, spins[2]=0 (tie).
REQ-037 rst=0, run=0, sample=0 -> each phase lasts 1 cycle, done asserts, no hang.
REQ-038 start pulsed during RUN -> ignored, cycle timing unchanged; start in DONE -> done clears, new run begins.
REQ-039 axi_rstn pulsed low during SAMPLE -> immediate IDLE, all outputs at reset values, next run correct.
REQ-040 CNT_W=4, sample=15, phase[0] always mismatched -> counter saturates at 15, spins[0]=1.

Source files
------------

// File: rtl/spin_readout_pkg.sv
// Shared constants for the spin readout block: FSM encoding, synchronizer depth
// and a small helper for "zero means one" cycle lengths.
package spin_readout_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HOLD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [31:0] at_least_one(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/spin_readout_sync_2ff.sv
// Multi-flop synchronizer for one asynchronous bit; depth comes from the package.
module sync_2ff
  import spin_readout_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] stage_d;
  logic [SYNC_DEPTH-1:0] stage_q;

  always_comb begin
    stage_d = {stage_q[SYNC_DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q = stage_q[SYNC_DEPTH-1];

endmodule

// File: rtl/spin_readout.sv
// Anneal-and-read controller: resets the oscillator array, lets it settle, then
// counts per-spin phase mismatches against the reference and decides spin values.
module spin_readout
  import spin_readout_pkg::*;
#(
  parameter int NUM_SPINS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         axi_rstn,
  input  logic                         start,
  input  logic [15:0]                  rst_cycles,
  input  logic [31:0]                  run_cycles,
  input  logic [CNT_W-1:0]             sample_cycles,
  input  logic                         ref_in,
  input  logic [NUM_SPINS-1:0]         phase_in,
  input  logic [$clog2(NUM_SPINS)-1:0] rd_idx,
  output logic                         ising_rstn,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_SPINS-1:0]         spins,
  output logic [31:0]                  rdata
);

  logic                 ref_s;
  logic [NUM_SPINS-1:0] phase_s;

  sync_2ff u_sync_ref (.clk(clk), .rst_n(axi_rstn), .d(ref_in), .q(ref_s));

  for (genvar g = 0; g < NUM_SPINS; g++) begin : g_sync
    sync_2ff u_sync (.clk(clk), .rst_n(axi_rstn), .d(phase_in[g]), .q(phase_s[g]));
  end

  logic [2:0]           state_d, state_q;
  logic [31:0]          cyc_d, cyc_q;
  logic [31:0]          run_len_d, run_len_q;
  logic [CNT_W-1:0]     sample_len_d, sample_len_q;
  logic [NUM_SPINS-1:0] spins_d, spins_q;
  logic [CNT_W-1:0]     cnt_d [NUM_SPINS];
  logic [CNT_W-1:0]     cnt_q [NUM_SPINS];
  logic [31:0]          rdata_d, rdata_q;

  // cyc_q counts down the remaining cycles of the current phase; 1 means last cycle
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    run_len_d    = run_len_q;
    sample_len_d = sample_len_q;
    spins_d      = spins_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_HOLD;
          cyc_d        = at_least_one({16'd0, rst_cycles});
          run_len_d    = at_least_one(run_cycles);
          sample_len_d = (sample_cycles == '0) ? CNT_W'(1) : sample_cycles;
          spins_d      = '0;
          for (int i = 0; i < NUM_SPINS; i++) cnt_d[i] = '0;
        end
      end
      ST_HOLD: begin
        if (cyc_q == 32'd1) begin
          state_d = ST_RUN;
          cyc_d   = run_len_q;
        end else begin
          cyc_d = cyc_q - 32'd1;
        end
      end
      ST_RUN: begin
        if (cyc_q == 32'd1) begin
          state_d = ST_SAMPLE;
          cyc_d   = 32'(sample_len_q);
        end else begin
          cyc_d = cyc_q - 32'd1;
        end
      end
      ST_SAMPLE: begin
        for (int i = 0; i < NUM_SPINS; i++) begin
          if ((phase_s[i] != ref_s) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // The decision includes the final window cycle, so it uses the next counter values
        if (cyc_q == 32'd1) begin
          state_d = ST_DONE;
          for (int i = 0; i < NUM_SPINS; i++) begin
            spins_d[i] = ({cnt_d[i], 1'b0} > {1'b0, sample_len_q});
          end
        end else begin
          cyc_d = cyc_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdata_d = (32'(rd_idx) < NUM_SPINS) ? 32'(cnt_q[rd_idx]) : 32'd0;
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      run_len_q    <= '0;
      sample_len_q <= '0;
      spins_q      <= '0;
      rdata_q      <= '0;
      for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      run_len_q    <= run_len_d;
      sample_len_q <= sample_len_d;
      spins_q      <= spins_d;
      rdata_q      <= rdata_d;
      for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy       = (state_q == ST_HOLD) || (state_q == ST_RUN) || (state_q == ST_SAMPLE);
  assign ising_rstn = (state_q != ST_IDLE) && (state_q != ST_HOLD);
  assign done       = (state_q == ST_DONE);
  assign spins      = spins_q;
  assign rdata      = rdata_q;

endmodule
